// File: rtl/vitdec_traceback.sv
// Survivor memory and traceback for the radix-4 Viterbi decoder: three circular decision banks,
// two trellis columns traced per cycle, decoded bits replayed in forward order via ping-pong buffer.
module vitdec_traceback #(
    parameter int unsigned r           = 2,
    parameter int unsigned nu          = 6,
    parameter int unsigned state       = 64,
    parameter int unsigned tb_cols     = 16,
    parameter int unsigned tb_cols_log = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_rst,
    input  logic               dec_valid,
    input  logic [0:state*r-1] decision,
    input  logic [nu-1:0]      start_state,
    output logic [0:r-1]       result,
    output logic               result_valid,
    output logic               tb_busy
);
    localparam int unsigned Depth = 3 * tb_cols;
    localparam int unsigned Aw    = $clog2(Depth);
    localparam int unsigned Cw    = tb_cols_log;
    localparam int unsigned Iw    = $clog2(state * r);

    typedef logic [0:state*r-1] col_t;
    typedef enum logic [1:0] {StIdle, StTrain, StDecode} tb_st_e;

    col_t         mem_q [Depth];
    logic [r-1:0] rev_q [2][tb_cols];

    logic [Cw-1:0] wr_col_q, wr_col_d, cnt_q, cnt_d, rd_cnt_q, rd_cnt_d;
    logic [1:0]    wr_bank_q, wr_bank_d, banks_filled_q, banks_filled_d, tb_bank_q, tb_bank_d;
    tb_st_e        st_q, st_d;
    logic [nu-1:0] tb_state_q, tb_state_d, s_mid, s_end;
    logic          fill_half_q, fill_half_d, rd_active_q, rd_active_d;
    logic [r-1:0]  result_q, result_d;
    logic          result_valid_q, result_valid_d, tb_busy_q, tb_busy_d;
    logic          wr_done, trigger, swap;
    logic [1:0]    dec_bank, rd_bank;
    logic [Cw-2:0] step;
    logic [Cw-1:0] col_hi, col_lo;

    // Predecessor: decision field of s becomes the oldest bits, s shifts toward the LSB.
    function automatic logic [nu-1:0] pred(input logic [nu-1:0] s, input col_t w);
        logic [Iw-1:0] idx;
        logic [r-1:0]  d;
        idx = Iw'(s) * Iw'(r);
        d   = w[idx +: r];
        return {d, s[nu-1:r]};
    endfunction

    function automatic logic [Aw-1:0] addr(input logic [1:0] bank, input logic [Cw-1:0] col);
        return Aw'(bank) * Aw'(tb_cols) + Aw'(col);
    endfunction

    always_comb begin
        wr_done  = dec_valid && (wr_col_q == Cw'(tb_cols - 1));
        trigger  = wr_done && (banks_filled_q != 2'd0);
        dec_bank = (tb_bank_q == 2'd0) ? 2'd2 : tb_bank_q - 2'd1;
        rd_bank  = (st_q == StDecode) ? dec_bank : tb_bank_q;
        step     = cnt_q[Cw-2:0];
        // Step k covers columns tb_cols-1-2k (newest) and tb_cols-2-2k.
        col_hi   = ~{step, 1'b0};
        col_lo   = ~{step, 1'b1};
        s_mid    = pred(tb_state_q, mem_q[addr(rd_bank, col_hi)]);
        s_end    = pred(s_mid, mem_q[addr(rd_bank, col_lo)]);
        swap     = (st_q == StDecode) && (cnt_q == '1);
    end

    always_comb begin
        wr_col_d       = wr_col_q;
        wr_bank_d      = wr_bank_q;
        banks_filled_d = banks_filled_q;
        st_d           = st_q;
        cnt_d          = cnt_q;
        tb_bank_d      = tb_bank_q;
        tb_state_d     = tb_state_q;
        fill_half_d    = fill_half_q;
        rd_active_d    = rd_active_q;
        rd_cnt_d       = rd_cnt_q;

        if (dec_valid) begin
            wr_col_d = wr_col_q + 1'b1;
        end
        if (wr_done) begin
            wr_bank_d = (wr_bank_q == 2'd2) ? 2'd0 : wr_bank_q + 2'd1;
            if (banks_filled_q != 2'd2) begin
                banks_filled_d = banks_filled_q + 2'd1;
            end
        end

        case (st_q)
            StTrain: begin
                tb_state_d = s_end;
                cnt_d      = cnt_q + 1'b1;
                st_d       = (step == '1) ? StDecode : StTrain;
            end
            StDecode: begin
                tb_state_d = s_end;
                cnt_d      = cnt_q + 1'b1;
                if (swap) begin
                    st_d = StIdle;
                end
            end
            default: ;
        endcase

        // A new bank may complete on the very edge the previous traceback finishes.
        if (trigger) begin
            st_d       = StTrain;
            cnt_d      = '0;
            tb_bank_d  = wr_bank_q;
            tb_state_d = start_state;
        end

        if (rd_active_q) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == '1) begin
                rd_active_d = 1'b0;
            end
        end
        if (swap) begin
            fill_half_d = ~fill_half_q;
            rd_active_d = 1'b1;
            rd_cnt_d    = '0;
        end

        result_valid_d = rd_active_q;
        result_d       = rd_active_q ? rev_q[~fill_half_q][rd_cnt_q] : '0;

        if (frame_rst) begin
            wr_col_d       = '0;
            wr_bank_d      = 2'd0;
            banks_filled_d = 2'd0;
            st_d           = StIdle;
            cnt_d          = '0;
            rd_active_d    = 1'b0;
            rd_cnt_d       = '0;
            result_d       = '0;
            result_valid_d = 1'b0;
        end

        tb_busy_d = (st_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (dec_valid && !frame_rst) begin
            mem_q[addr(wr_bank_q, wr_col_q)] <= decision;
        end
        if (st_q == StDecode) begin
            rev_q[fill_half_q][col_hi] <= tb_state_q[r-1:0];
            rev_q[fill_half_q][col_lo] <= s_mid[r-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_col_q       <= '0;
            wr_bank_q      <= 2'd0;
            banks_filled_q <= 2'd0;
            st_q           <= StIdle;
            cnt_q          <= '0;
            tb_bank_q      <= 2'd0;
            tb_state_q     <= '0;
            fill_half_q    <= 1'b0;
            rd_active_q    <= 1'b0;
            rd_cnt_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            tb_busy_q      <= 1'b0;
        end else begin
            wr_col_q       <= wr_col_d;
            wr_bank_q      <= wr_bank_d;
            banks_filled_q <= banks_filled_d;
            st_q           <= st_d;
            cnt_q          <= cnt_d;
            tb_bank_q      <= tb_bank_d;
            tb_state_q     <= tb_state_d;
            fill_half_q    <= fill_half_d;
            rd_active_q    <= rd_active_d;
            rd_cnt_q       <= rd_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            tb_busy_q      <= tb_busy_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign tb_busy      = tb_busy_q;

endmodule

// File: tb/tb_vitdec_traceback.sv
// Directed bench for vitdec_traceback: uniform and column-varying decision patterns,
// back-to-back banks, gapped input, frame restart and asynchronous reset.
module tb_vitdec_traceback;
    localparam int R   = 2;
    localparam int NU  = 6;
    localparam int NS  = 64;
    localparam int TBC = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_rst = 1'b0;
    logic              dec_valid = 1'b0;
    logic [0:NS*R-1]   decision = '0;
    logic [NU-1:0]     start_state = '0;
    logic [0:R-1]      result;
    logic              result_valid;
    logic              tb_busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  exp_col [TBC];
    logic        any_valid;

    always #5 clk = ~clk;

    vitdec_traceback #(
        .r           (R),
        .nu          (NU),
        .state       (NS),
        .tb_cols     (TBC),
        .tb_cols_log (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_rst    (frame_rst),
        .dec_valid    (dec_valid),
        .decision     (decision),
        .start_state  (start_state),
        .result       (result),
        .result_valid (result_valid),
        .tb_busy      (tb_busy)
    );

    // Every state's decision field set to f.
    function automatic logic [0:NS*R-1] mk(input logic [1:0] f);
        return {NS{f}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int n, input logic [1:0] f, input bit gap);
        for (int i = 0; i < n; i++) begin
            dec_valid = 1'b1;
            decision  = mk(f);
            tick();
            dec_valid = 1'b0;
            if (gap && i < n - 1) tick();
        end
    endtask

    task automatic pulse_frame();
        frame_rst = 1'b1;
        tick();
        frame_rst = 1'b0;
    endtask

    task automatic set_exp(input logic [1:0] v);
        for (int c = 0; c < TBC; c++) exp_col[c] = v;
    endtask

    // Called right after the edge that completes the second bank.
    task automatic expect_burst(input string tag);
        for (int i = 1; i <= 2 * TBC; i++) begin
            tick();
            check({tag, ".valid"}, 8'(result_valid), 8'(i > TBC));
            if (i <= TBC) check({tag, ".busy"}, 8'(tb_busy), 8'(i < TBC));
            else check({tag, ".result"}, 8'(result), 8'(exp_col[i-TBC-1]));
        end
        tick();
        check({tag, ".valid_end"}, 8'(result_valid), 8'd0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        any_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            any_valid = any_valid | result_valid;
        end
        check(tag, 8'(any_valid), 8'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        check("rst.result", 8'(result), 8'd0);
        check("rst.valid", 8'(result_valid), 8'd0);
        check("rst.busy", 8'(tb_busy), 8'd0);
        tick();
        rst = 1'b1;
        tick();

        // All-zero, 48 contiguous columns: two bursts back to back.
        start_state = '0;
        send(32, 2'b00, 1'b0);
        for (int i = 1; i <= 49; i++) begin
            dec_valid = (i <= 16);
            decision  = mk(2'b00);
            tick();
            check("zero.valid", 8'(result_valid), 8'(i >= 17 && i <= 48));
            check("zero.busy", 8'(tb_busy), 8'(i <= 31));
            if (i >= 17 && i <= 48) check("zero.result", 8'(result), 8'd0);
        end
        dec_valid = 1'b0;

        pulse_frame();
        start_state = 6'd63;
        set_exp(2'b11);
        send(32, 2'b11, 1'b0);
        expect_burst("ones");

        // Path 0->16->20->21->21..., every decoded pair is 01.
        pulse_frame();
        start_state = 6'd0;
        set_exp(2'b01);
        send(32, 2'b01, 1'b0);
        expect_burst("conv");

        // Bank 0 column c uses field c mod 4; bank 1 all 01 settles at state 21.
        // State after column c (c<=12) is {d[c+1], d[c+2], d[c+3]}, so output c is d[c+3].
        pulse_frame();
        start_state = 6'd37;
        for (int c = 0; c < TBC; c++) begin
            dec_valid = 1'b1;
            decision  = mk(2'(c));
            tick();
        end
        dec_valid = 1'b0;
        send(16, 2'b01, 1'b0);
        for (int c = 0; c < TBC; c++) exp_col[c] = (c <= 12) ? 2'((c + 3) % 4) : 2'b01;
        expect_burst("mixed");

        pulse_frame();
        start_state = 6'd63;
        set_exp(2'b11);
        send(32, 2'b11, 1'b1);
        expect_burst("gap");

        // Frame restart during traceback with a coincident column.
        pulse_frame();
        send(32, 2'b11, 1'b0);
        tick();
        tick();
        check("frst.busy_pre", 8'(tb_busy), 8'd1);
        dec_valid = 1'b1;
        frame_rst = 1'b1;
        decision  = mk(2'b11);
        tick();
        frame_rst = 1'b0;
        dec_valid = 1'b0;
        check("frst.busy", 8'(tb_busy), 8'd0);
        check("frst.valid", 8'(result_valid), 8'd0);
        send(31, 2'b11, 1'b0);
        check("frst.busy31", 8'(tb_busy), 8'd0);
        expect_quiet("frst.quiet", 20);
        send(1, 2'b11, 1'b0);
        expect_burst("frst");

        // Asynchronous reset in the middle of readout.
        pulse_frame();
        send(32, 2'b11, 1'b0);
        repeat (20) tick();
        check("arst.valid_pre", 8'(result_valid), 8'd1);
        check("arst.result_pre", 8'(result), 8'd3);
        #3 rst = 1'b0;
        #1;
        check("arst.result", 8'(result), 8'd0);
        check("arst.valid", 8'(result_valid), 8'd0);
        check("arst.busy", 8'(tb_busy), 8'd0);
        tick();
        rst = 1'b1;
        tick();
        send(16, 2'b11, 1'b0);
        check("arst.busy16", 8'(tb_busy), 8'd0);
        expect_quiet("arst.quiet", 40);
        send(16, 2'b11, 1'b0);
        expect_burst("arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vitdec_traceback.md
# vitdec_traceback

Survivor-memory and traceback stage of the radix-4, 64-state Viterbi decoder, directly downstream of `vitdec_forward`. It stores the per-state decision vectors produced by the add-compare-select stage in a three-bank circular survivor memory. It traces back two trellis columns per cycle, and emits decoded bits in forward time order, R bits per cycle, through a ping-pong reversal buffer.

## Interface
- `r`, default 2: decoded bits per trellis column (radix 2^r).
- `nu`, default 6: constraint length minus 1; state width.
- `state`, default 64: number of states, 2^nu.
- `tb_cols`, default 16: columns per bank; must be even.
- `tb_cols_log`, default 4: log2(`tb_cols`).

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `frame_rst`  in  1: synchronous, active-high frame restart.
- `dec_valid`  in  1: `decision` holds a new column this cycle.
- `decision`  in  state*r: declared [0:state*r-1]; state s field at indices s*r..s*r+r-1, index s*r is the MSB.
- `start_state`  in  nu: state at which traceback starts (ACS best state, or 0).
- `result`  out  r: decoded bits, declared [0:r-1]; `result[0]` is the earlier bit.
- `result_valid`  out  1: `result` is valid this cycle.
- `tb_busy`  out  1: a traceback is in progress.

## Operation
- **Trellis convention.** The state holds the newest nu input bits, with the newest bit at the LSB.
  - The next state is ((s << r) | u) mod 2^nu.
  - The predecessor is (d << (nu-r)) | (s >> r), where d is the decision field of s in that column.
  - The decoded bits of a column are the low r bits of the state after that column; bit r-1 is the earlier bit.
- **Write side.**
  - Pointers: `wr_col` (0..tb_cols-1) and `wr_bank` (0..2).
  - Each `dec_valid` cycle writes `decision` to [wr_bank][wr_col], then increments `wr_col`.
  - On wrap, `wr_bank` advances modulo 3.
  - A saturating counter `banks_filled` (0..2) increments on each bank completion.
- **Traceback trigger.** Bank b completes when column tb_cols-1 is written. If `banks_filled` was already ≥1 (bank b-1 is full):
  - load `tb_state` ← `start_state` on the same edge;
  - enter TRAIN.
- **FSM.** States are IDLE → TRAIN → DECODE → IDLE.
  - Each step processes two columns with two chained lookups: newest column first, then the next older.
  - TRAIN runs tb_cols/2 steps over bank b, from column tb_cols-1 down to 0. It produces no output.
  - DECODE runs tb_cols/2 steps over bank (b+2) mod 3. Each step writes 2r decoded bits into the fill half of the reversal buffer, newest column at the highest address.
  - After the last DECODE step: swap the reversal halves and start readout.
- **Readout.** Over tb_cols consecutive cycles, output column 0 through column tb_cols-1 of the decoded bank, with `result_valid`=1.
- **Throughput.**
  - The write side never stalls.
  - A traceback (tb_cols cycles) always finishes before the next bank can complete.
  - Readout always finishes before the next swap.
- **`frame_rst`** (highest priority after `rst`):
  - clears `wr_col`, `wr_bank`, `banks_filled`, the FSM (→ IDLE) and the readout counter;
  - drives `result`=0 and `result_valid`=0;
  - aborts any traceback or readout in progress.
  - A `dec_valid` column presented in the same cycle is dropped.
  - Memory contents are not cleared.
- **`rst`** has the same effect as `frame_rst`, asynchronously.
- **Widths.** All pointers wrap modulo their range; there is no metric arithmetic in this block.

## Timing
- **Reset values:** `result`=0, `result_valid`=0, `tb_busy`=0.
- **Traceback start.** Let E be the edge that writes the last column of bank b.
  - TRAIN steps occur on edges E+1..E+tb_cols/2.
  - DECODE steps occur on edges E+tb_cols/2+1..E+tb_cols.
  - `tb_busy`=1 in the cycles between edges E and E+tb_cols.
- **Readout.** `result_valid`=1 for the tb_cols cycles following edge E+tb_cols, i.e. registered outputs updated on edges E+tb_cols+1..E+2·tb_cols.
  - Latency from the last write of bank b to the first `result` of bank b-1 is tb_cols+1 edges.
- **Back-to-back.** A traceback may begin on the same edge that the previous one completes.
- **Gaps.** Gaps in `dec_valid` only delay bank completion. Traceback and readout never pause once started.
- **Output delay.** The first output appears only after the second bank completes, and covers bank 0.

## Test plan
- **Reset.** Assert `rst`=0 mid-readout → `result`=0, `result_valid`=0 and `tb_busy`=0 immediately. Output resumes only after two new full banks.
- **All-zero decisions.** `start_state`=0, 48 consecutive columns → `result_valid` high 17 edges after the 32nd write, for 16 cycles, `result`=2'b00. A second burst of 16 cycles follows after the 48th write.
- **All-ones decisions.** All fields 2'b11, `start_state`=6'd63 → every output `result`=2'b11.
- **Converging path.** All fields 2'b01, `start_state`=0 → path 0→16→20→21→21…; all 16 outputs of bank 0 are `result`=2'b01.
- **Gapped input.** `dec_valid` toggling every other cycle with the all-ones stimulus → identical outputs, each burst 16 cycles contiguous.
- **Frame restart mid-traceback.** `frame_rst` pulse while `tb_busy`=1, coincident with `dec_valid`=1 → `tb_busy` and `result_valid` are 0 next cycle, the coincident column is dropped, and the next output requires 32 new columns.
